// File: rtl/ac_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ac_meas_pkg
//  Purpose  : Shared types and helpers for the AC measurement blocks.
//             Holds the measurement FSM state encoding, width calculators for
//             the accumulator and quotient paths, and an unsigned saturation
//             helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ac_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } meas_state_e;

  // Accumulator width: one sample magnitude times the window length.
  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned win_log2);
    return sample_w + win_log2;
  endfunction

  // Quotient width: the dividend is the output sum pre-shifted by FRAC_W.
  function automatic int unsigned quot_width(input int unsigned sample_w,
                                             input int unsigned win_log2,
                                             input int unsigned frac_w);
    return acc_width(sample_w, win_log2) + frac_w;
  endfunction

  // Clamp an unsigned value (up to 64 bits) to the largest out_w-bit value.
  function automatic logic [63:0] sat_unsigned(input logic [63:0]   val,
                                               input int unsigned   out_w);
    logic [63:0] max_v;
    if (out_w >= 64) begin
      return val;
    end
    max_v = (64'd1 << out_w) - 64'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ac_gain_meter_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Restoring unsigned divider, one quotient bit per clock.
//             The first quotient bit is produced on the cycle start is
//             accepted, so a full WIDTH-bit quotient takes exactly WIDTH
//             clocks; done pulses on the cycle after the last bit.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             start           - accept dividend/divisor (ignored while busy)
//             dividend        - unsigned dividend
//             divisor         - unsigned divisor (must be non-zero)
//             done            - one-cycle pulse, quotient valid
//             quotient        - result, held until the next start
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int unsigned WIDTH = 24  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] w_src_rem;
  logic [WIDTH-1:0] w_src_dvd;
  logic [WIDTH-1:0] w_src_dvs;
  logic [WIDTH:0]   w_trial;
  logic             w_take;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_dvd_step;

  // One restoring step; when idle the step operates on the fresh operands so
  // the first bit is resolved in the start cycle.
  always_comb begin
    w_src_rem = rem_q;
    w_src_dvd = dvd_q;
    w_src_dvs = dvs_q;
    if (!busy_q) begin
      w_src_rem = '0;
      w_src_dvd = dividend;
      w_src_dvs = divisor;
    end
    w_trial    = {w_src_rem, w_src_dvd[WIDTH-1]};
    w_take     = (w_trial >= {1'b0, w_src_dvs});
    w_rem_step = w_take ? WIDTH'(w_trial - {1'b0, w_src_dvs}) : w_trial[WIDTH-1:0];
    w_dvd_step = {w_src_dvd[WIDTH-2:0], w_take};
  end

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      rem_d = w_rem_step;
      dvd_d = w_dvd_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = w_rem_step;
      dvd_d  = w_dvd_step;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = dvd_q;

endmodule
`default_nettype wire

// File: rtl/ac_gain_meter.sv
`default_nettype none
// ============================================================================
//  Module   : ac_gain_meter
//  Purpose  : Amplitude gain |Out|/|In| of an amplifier under test, taken as
//             the ratio of mean absolute output and input samples over a
//             window of 2^WIN_LOG2 valid samples. Result is unsigned
//             Q(GAIN_W-FRAC_W).FRAC_W, truncated and saturated.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             start           - begin a measurement (ignored unless idle)
//             in_valid        - in_sample/out_sample valid this cycle
//             in_sample       - signed stimulus sample
//             out_sample      - signed response sample
//             busy            - measurement in progress
//             done            - one-cycle result strobe
//             gain            - |Out|/|In| ratio
//             overflow        - ratio saturated to all-ones
//             in_zero         - input sum was zero, gain forced to all-ones
//  Revision : 1.0 - initial release
// ============================================================================
module ac_gain_meter
  import ac_meas_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned GAIN_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [SAMPLE_W-1:0] out_sample,
  output logic                busy,
  output logic                done,
  output logic [GAIN_W-1:0]   gain,
  output logic                overflow,
  output logic                in_zero
);

  localparam int unsigned ACC_W = acc_width(SAMPLE_W, WIN_LOG2);
  localparam int unsigned Q_W   = quot_width(SAMPLE_W, WIN_LOG2, FRAC_W);

  meas_state_e         state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic                overflow_q, overflow_d;
  logic                in_zero_q, in_zero_d;
  logic [ACC_W-1:0]    sum_in_q, sum_in_d;
  logic [ACC_W-1:0]    sum_out_q, sum_out_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;

  logic [SAMPLE_W-1:0] w_abs_in;
  logic [SAMPLE_W-1:0] w_abs_out;
  logic [ACC_W-1:0]    w_sum_in_nxt;
  logic [ACC_W-1:0]    w_sum_out_nxt;
  logic                w_last;
  logic                w_div_start;
  logic                w_div_done;
  logic [Q_W-1:0]      w_quot;
  logic [63:0]         w_quot_wide;
  logic [63:0]         w_quot_sat;
  logic                w_quot_ovf;

  // Magnitude as SAMPLE_W-bit unsigned: the most-negative code maps to
  // 2^(SAMPLE_W-1), which is representable unsigned, so nothing wraps.
  always_comb begin
    w_abs_in  = in_sample[SAMPLE_W-1]  ? (~in_sample  + SAMPLE_W'(1)) : in_sample;
    w_abs_out = out_sample[SAMPLE_W-1] ? (~out_sample + SAMPLE_W'(1)) : out_sample;
  end

  assign w_sum_in_nxt  = sum_in_q  + ACC_W'(w_abs_in);
  assign w_sum_out_nxt = sum_out_q + ACC_W'(w_abs_out);
  assign w_last        = &cnt_q;

  // The divider takes the sums including the final sample directly, so it
  // starts on the same edge that accepts that sample.
  assign w_div_start = (state_q == ACCUM) && in_valid && w_last && (w_sum_in_nxt != '0);

  seq_divider #(
    .WIDTH (Q_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend ({w_sum_out_nxt, {FRAC_W{1'b0}}}),
    .divisor  ({{FRAC_W{1'b0}}, w_sum_in_nxt}),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  assign w_quot_wide = 64'(w_quot);
  assign w_quot_sat  = sat_unsigned(w_quot_wide, GAIN_W);
  assign w_quot_ovf  = (w_quot_wide >> GAIN_W) != 64'd0;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gain_d     = gain_q;
    overflow_d = overflow_q;
    in_zero_d  = in_zero_q;
    sum_in_d   = sum_in_q;
    sum_out_d  = sum_out_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_in_d  = '0;
          sum_out_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          sum_in_d  = w_sum_in_nxt;
          sum_out_d = w_sum_out_nxt;
          cnt_d     = cnt_q + WIN_LOG2'(1);
          if (w_last) begin
            if (w_sum_in_nxt == '0) begin
              state_d    = DONE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              gain_d     = '1;
              overflow_d = 1'b1;
              in_zero_d  = 1'b1;
            end else begin
              state_d = DIVIDE;
            end
          end
        end
      end
      DIVIDE: begin
        if (w_div_done) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          gain_d     = GAIN_W'(w_quot_sat);
          overflow_d = w_quot_ovf;
          in_zero_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gain_q     <= '0;
      overflow_q <= 1'b0;
      in_zero_q  <= 1'b0;
      sum_in_q   <= '0;
      sum_out_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gain_q     <= gain_d;
      overflow_q <= overflow_d;
      in_zero_q  <= in_zero_d;
      sum_in_q   <= sum_in_d;
      sum_out_q  <= sum_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign gain     = gain_q;
  assign overflow = overflow_q;
  assign in_zero  = in_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_gain_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ac_gain_meter
//  Purpose  : Scoreboard bench for ac_gain_meter with a 16-sample window.
//             Stimulus pushes the hand-computed result and its due cycle;
//             a negedge monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ac_gain_meter;

  localparam int unsigned SW = 12;
  localparam int unsigned WL = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned GW = 16;
  localparam int unsigned QW = SW + WL + FW;  // 24

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_sample = '0;
  logic [SW-1:0] out_sample = '0;
  logic          busy;
  logic          done;
  logic [GW-1:0] gain;
  logic          overflow;
  logic          in_zero;

  ac_gain_meter #(
    .SAMPLE_W (SW),
    .WIN_LOG2 (WL),
    .FRAC_W   (FW),
    .GAIN_W   (GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_sample (out_sample),
    .busy       (busy),
    .done       (done),
    .gain       (gain),
    .overflow   (overflow),
    .in_zero    (in_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [GW-1:0] gain;
    logic          ovf;
    logic          zero;
    int            cyc;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_gain"},     32'(gain),     32'(e.gain));
        check({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
        check({e.name, "_in_zero"},  32'(in_zero),  32'(e.zero));
        check({e.name, "_latency"},  32'(cyc),      32'(e.cyc));
      end
    end
    prev_done <= done;
  end

  // One measurement: start pulse, 16 samples alternating even/odd values,
  // optional idle cycle after each sample, optional start inside ACCUM.
  task automatic run_window(input string name, input int ie, input int io,
                            input int oe, input int oo, input bit gap,
                            input logic [GW-1:0] eg, input bit eo, input bit ez,
                            input bit start_mid, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid   = 1'b1;
      in_sample  = SW'((i % 2 == 0) ? ie : io);
      out_sample = SW'((i % 2 == 0) ? oe : oo);
      if (start_mid && i == 5) start = 1'b1;
      if (i == 15 && push) begin
        e.gain = eg;
        e.ovf  = eo;
        e.zero = ez;
        e.cyc  = cyc + (ez ? 1 : int'(QW) + 1);
        e.name = name;
        sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 100 cycles, expected done", name);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_done",     32'(done),     32'd0);
    check("reset_gain",     32'(gain),     32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_in_zero",  32'(in_zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 300/100 -> 3.0
    run_window("t1", 100, -100, 300, -300, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_empty("t1");
    // 2: 50/100 -> 0.5, then same with gaps
    run_window("t2", 100, -100, 50, -50, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_empty("t2");
    run_window("t2gap", 100, -100, 50, -50, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_empty("t2gap");
    // 3: most-negative output magnitude
    run_window("t3", 1024, 1024, -2048, -2048, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_empty("t3");

    // 5: start mid-ACCUM, mid-DIVIDE and in the DONE cycle
    run_window("t5", 100, -100, 300, -300, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_start_in_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_start_in_done_busy2", 32'(busy), 32'd0);
    wait_empty("t5");

    // 4: saturation and zero input
    run_window("t4ovf", 1, -1, 2047, -2047, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_empty("t4ovf");
    run_window("t4zero", 0, 0, 5, -5, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_empty("t4zero");

    // 6: asynchronous reset during DIVIDE, then a clean run
    run_window("t6abort", 100, -100, 300, -300, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    check("t6_pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_busy",     32'(busy),     32'd0);
    check("t6_async_done",     32'(done),     32'd0);
    check("t6_async_gain",     32'(gain),     32'd0);
    check("t6_async_overflow", 32'(overflow), 32'd0);
    check("t6_async_in_zero",  32'(in_zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_window("t6", 100, -100, 50, -50, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_empty("t6");

    repeat (30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
